// File: rtl/attn_softmax_col_unit.sv
// Column softmax stage: requantizes an N-element score column, optionally min-subtract-square-requantize.
// Latency 2 cycles (mode 0) or N+3 cycles (mode 1); in_ready only in IDLE, result held until out_ready.
module attn_softmax_col_unit #(
  parameter int N     = 8,
  parameter int IN_W  = 36,
  parameter int OUT_W = 16,
  parameter int FRAC  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*IN_W-1:0]  in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*OUT_W-1:0] out_data,
  output logic [N-1:0]       out_sat,
  output logic               busy
);
  localparam int SW = 2 * OUT_W;
  localparam int MW = (IN_W > SW) ? IN_W : SW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, QUANT, MIN, SQ, REQ, OUT} state_t;
  state_t state;

  logic [N*IN_W-1:0] data_r;
  logic              mode_r;
  logic [OUT_W-1:0]  q_r [N];
  logic [SW-1:0]     s_r [N];
  logic [OUT_W-1:0]  min_r;
  logic [IW-1:0]     idx;

  logic [OUT_W:0]    q_in [N];
  logic [OUT_W:0]    q_sq [N];
  logic [OUT_W-1:0]  diff [N];
  logic [SW-1:0]     sq   [N];

  // Returns {sat, value}: round half up, clamp to all ones on overflow.
  function automatic logic [OUT_W:0] requant(input logic [MW-1:0] x);
    logic [MW-1:0]    hi;
    logic [OUT_W-1:0] mid;
    logic             rnd;
    logic             sat;
    hi  = x >> (FRAC + OUT_W);
    mid = x[FRAC+OUT_W-1:FRAC];
    rnd = x[FRAC-1];
    sat = (|hi) || ((&mid) && rnd);
    return {sat, sat ? {OUT_W{1'b1}} : mid + OUT_W'(rnd)};
  endfunction

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      q_in[k] = requant(MW'(data_r[k*IN_W +: IN_W]));
      q_sq[k] = requant(MW'(s_r[k]));
      diff[k] = q_r[k] - min_r;
      sq[k]   = {{OUT_W{1'b0}}, diff[k]} * {{OUT_W{1'b0}}, diff[k]};
      out_data[k*OUT_W +: OUT_W] = q_r[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_sat   <= '0;
      data_r    <= '0;
      mode_r    <= 1'b0;
      min_r     <= '0;
      idx       <= '0;
      for (int k = 0; k < N; k++) begin
        q_r[k] <= '0;
        s_r[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r   <= in_data;
            mode_r   <= in_mode;
            out_sat  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= QUANT;
          end
        end
        QUANT: begin
          for (int k = 0; k < N; k++) begin
            q_r[k]     <= q_in[k][OUT_W-1:0];
            out_sat[k] <= q_in[k][OUT_W];
          end
          if (mode_r) begin
            min_r <= q_in[0][OUT_W-1:0];
            idx   <= IW'(1);
            state <= MIN;
          end else begin
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        MIN: begin
          if (q_r[idx] < min_r) min_r <= q_r[idx];
          idx <= idx + IW'(1);
          if (idx == IW'(N - 1)) state <= SQ;
        end
        SQ: begin
          for (int k = 0; k < N; k++) s_r[k] <= sq[k];
          state <= REQ;
        end
        REQ: begin
          for (int k = 0; k < N; k++) begin
            q_r[k]     <= q_sq[k][OUT_W-1:0];
            out_sat[k] <= out_sat[k] | q_sq[k][OUT_W];
          end
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
